mm_matrix_store: RTL and testbench
==================================

// Module: mm_matrix_store
// PURPOSE
//  Memory-side responder for the matrix-multiply engine bus (i, j, read, write, index, read_data, write_data, finish).
//  Holds matrix sizes, operands A (ma x mb) and B (mb x mc), and captures result C (ma x mc) written back by the engine.
//  A host port preloads sizes/operands and dumps C; a small FSM sequences LOAD -> RUN -> DONE and holds the engine in reset outside RUN.
// PARAMETERS
//  N     20  operand width; sizes and indices are N bits, results are 2N bits
//  MAXD  4   max matrix dimension; each array is MAXD*MAXD entries
// PORTS
//  clk         in   1    clock
//  reset       in   1    synchronous, active-high
//  eng_reset   out  1    reset to engine; high in LOAD and DONE
//  i, j        in   N    engine row/col index
//  read        in   1    engine read strobe
//  write       in   1    engine write strobe
//  index       in   1    0 = A operand, 1 = B operand
//  finish      in   1    engine completion level
//  read_data   out  N    signed operand/size returned to engine, combinational
//  write_data  in   2N   signed result from engine
//  ld_valid    in   1    host load request
//  ld_ready    out  1    high only in LOAD
//  ld_sel      in   2    0 = size (ld_row selects ma/mb/mc), 1 = A, 2 = B, 3 = reserved
//  ld_row, ld_col in $clog2(MAXD)  load address
//  ld_data     in   N    load value
//  start       in   1    LOAD -> RUN request
//  dump_row, dump_col in $clog2(MAXD)  C read address
//  dump_data   out  2N   C[dump_row][dump_col], registered, 1-cycle latency
//  busy        out  1    state == RUN
//  done        out  1    state == DONE
//  wr_count    out  8    engine writes accepted since start
//  err         out  1    sticky protocol/config error
// BEHAVIOUR
//  Reset: state = LOAD; ma/mb/mc, A, B, C, wr_count, err, dump_data = 0. eng_reset = 1, ld_ready = 1, busy = 0, done = 0.
//  LOAD: host write fires on ld_valid & ld_ready, effective next edge. ld_sel = 3 or size ld_row > 2 is ignored and sets err.
//    On start: if any size is 0 or > MAXD -> err = 1 and stay in LOAD.
//    Otherwise C and wr_count are cleared and state moves to RUN the next cycle.
//  RUN: eng_reset = 0, ld_ready = 0 (ld_valid ignored), start ignored.
//    Bus decode on each cycle:
//    - read & write: size query. read_data = ma / mb / mc for i = 0 / 1 / 2; i > 2 returns 0 and sets err.
//    - read & !write: read_data = index ? B[i][j] : A[i][j].
//    - !read & write: C[i][j] <= write_data on the clock edge; wr_count += 1, saturating at 255.
//    - neither: read_data = 0.
//    i >= MAXD or j >= MAXD on a read or write: read_data = 0, write is dropped, err is set.
//    finish = 1 in RUN -> DONE next cycle. A write coincident with finish is still committed.
//  DONE: eng_reset = 1, done = 1. The engine bus is ignored and read_data = 0.
//    start -> clears C, wr_count and err, then goes to RUN (rerun with the same operands).
//    ld_valid in DONE is ignored; to reload operands, apply reset.
//  read_data is purely combinational from i/j/read/write/index and state, so the engine can sample it in the same cycle.
//  dump_data is readable in every state.
//  reset mid-RUN aborts immediately and forces all reset values (arrays included) in one cycle.
// STRUCTURE
//  Shared package mm_pkg: state encoding (ST_LOAD, ST_RUN, ST_DONE), LD_SEL_* constants, N / MAXD defaults.
//  Sub-module mm_regfile (parameterised width/depth; async read, sync write, sync clear) instantiated for A, B and C.
//  The FSM, size registers and bus decode live in the top module.
// TESTING
//  1. Load ma=2, mb=3, mc=2 with A=[1 2 3;4 5 6], B=[7 8;9 10;11 12]; start; run the real engine.
//     -> C = [58 64;139 154], wr_count = 4, done = 1, err = 0.
//  2. In RUN, drive read=1, write=1 with i = 0/1/2/3.
//     -> read_data = 2/3/2/0; err set on i = 3.
//  3. Load with mb = 0 (or 5 when MAXD = 4), then start. -> stays in LOAD, err = 1, eng_reset stays high.
//  4. Engine write at i = 4, j = 0. -> C unchanged, wr_count unchanged, err = 1.
//     Negative products: A=[-3], B=[7] -> C[0][0] = -21, sign-extended to 2N bits.
//  5. Assert reset mid-RUN after 2 writes. -> state LOAD, C all 0, wr_count 0, eng_reset 1 on the next cycle.
//  6. From DONE, pulse start. -> C cleared, wr_count 0, then same C as scenario 1 on completion;
//     ld_valid in RUN/DONE leaves A/B unchanged.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply operand/result store.
package mm_pkg;

  localparam int N_DEF    = 20;
  localparam int MAXD_DEF = 4;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] LD_SEL_SIZE = 2'd0;
  localparam logic [1:0] LD_SEL_A    = 2'd1;
  localparam logic [1:0] LD_SEL_B    = 2'd2;
  localparam logic [1:0] LD_SEL_RSVD = 2'd3;

endpackage

// File: rtl/mm_regfile.sv
// Flat register file: asynchronous read, synchronous write, synchronous clear of every entry.
module mm_regfile #(
  parameter int W     = 20,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Clear wipes every entry in one cycle; otherwise a single write port.
  // NOTE: the array is cleared explicitly because a restarted run must never see stale results,
  // so this stays a flop array rather than an inferred RAM without a clear.
  // NOTE: non-blocking assignments here so every reader of mem_q sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mm_matrix_store.sv
// Memory-side responder for the matrix-multiply engine: holds sizes and operands A/B,
// captures result C, and sequences LOAD -> RUN -> DONE while gating the engine reset.
module mm_matrix_store
  import mm_pkg::*;
#(
  parameter int  N     = N_DEF,
  parameter int  MAXD  = MAXD_DEF,
  localparam int RW    = $clog2(MAXD),
  localparam int DEPTH = MAXD * MAXD,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                eng_reset,
  input  logic [N-1:0]        i,
  input  logic [N-1:0]        j,
  input  logic                read,
  input  logic                write,
  input  logic                index,
  input  logic                finish,
  output logic signed [N-1:0] read_data,
  input  logic [2*N-1:0]      write_data,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [1:0]          ld_sel,
  input  logic [RW-1:0]       ld_row,
  input  logic [RW-1:0]       ld_col,
  input  logic [N-1:0]        ld_data,
  input  logic                start,
  input  logic [RW-1:0]       dump_row,
  input  logic [RW-1:0]       dump_col,
  output logic [2*N-1:0]      dump_data,
  output logic                busy,
  output logic                done,
  output logic [7:0]          wr_count,
  output logic                err
);

  function automatic logic [AW-1:0] rc_addr(logic [RW-1:0] r, logic [RW-1:0] c);
    return AW'(r) * AW'(MAXD) + AW'(c);
  endfunction

  function automatic logic size_ok(logic [N-1:0] s);
    return (s != '0) && (s <= N'(MAXD));
  endfunction

  state_e          state_q, state_d;
  logic [N-1:0]    ma_q, mb_q, mc_q;
  logic            err_q;
  logic [7:0]      wr_count_q;
  logic [2*N-1:0]  dump_data_q;

  logic            ld_fire, a_we, b_we, ld_err;
  logic            start_run, start_bad, rerun, clr_c;
  logic            idx_ok, c_we, bus_err;
  logic [AW-1:0]   eng_addr;
  logic [N-1:0]    a_rdata, b_rdata;
  logic [2*N-1:0]  c_rdata;

  assign ld_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign eng_reset = !busy;
  assign err       = err_q;
  assign wr_count  = wr_count_q;
  assign dump_data = dump_data_q;

  assign ld_fire   = ld_valid && ld_ready;
  assign start_run = ld_ready && start && size_ok(ma_q) && size_ok(mb_q) && size_ok(mc_q);
  assign start_bad = ld_ready && start && !start_run;
  assign rerun     = done && start;
  assign clr_c     = reset || start_run || rerun;

  assign idx_ok   = (i < N'(MAXD)) && (j < N'(MAXD));
  assign eng_addr = rc_addr(i[RW-1:0], j[RW-1:0]);

  // Host load decode: route the write to sizes, A or B, flag malformed requests.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    a_we   = 1'b0;
    b_we   = 1'b0;
    ld_err = 1'b0;
    if (ld_fire) begin
      case (ld_sel)
        LD_SEL_SIZE: ld_err = (int'(ld_row) > 2);
        LD_SEL_A:    a_we   = 1'b1;
        LD_SEL_B:    b_we   = 1'b1;
        default:     ld_err = 1'b1;
      endcase
    end
  end

  // Engine bus decode: size query, operand read, or result write; bus is dead outside RUN.
  always_comb begin
    read_data = '0;
    c_we      = 1'b0;
    bus_err   = 1'b0;
    if (busy) begin
      if (read && write) begin
        if (i == N'(0))      read_data = ma_q;
        else if (i == N'(1)) read_data = mb_q;
        else if (i == N'(2)) read_data = mc_q;
        else                 bus_err   = 1'b1;
      end else if (read || write) begin
        if (!idx_ok)   bus_err   = 1'b1;
        else if (read) read_data = index ? b_rdata : a_rdata;
        else           c_we      = 1'b1;
      end
    end
  end

  // Next-state logic for the LOAD -> RUN -> DONE sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (start_run) state_d = ST_RUN;
      ST_RUN:  if (finish)    state_d = ST_DONE;
      ST_DONE: if (start)     state_d = ST_RUN;
      default:                state_d = ST_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  // Matrix size registers, written only by the host in LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      ma_q <= '0;
      mb_q <= '0;
      mc_q <= '0;
    end else if (ld_fire && ld_sel == LD_SEL_SIZE) begin
      case (int'(ld_row))
        0:       ma_q <= ld_data;
        1:       mb_q <= ld_data;
        2:       mc_q <= ld_data;
        default: ;
      endcase
    end
  end

  // Sticky error flag; only a rerun from DONE or reset clears it.
  always_ff @(posedge clk) begin
    if (reset || rerun)                         err_q <= 1'b0;
    else if (ld_err || start_bad || bus_err)    err_q <= 1'b1;
  end

  // Count accepted engine writes, saturating; restarted on every entry to RUN.
  always_ff @(posedge clk) begin
    if (reset || start_run || rerun)      wr_count_q <= '0;
    else if (c_we && wr_count_q != 8'hFF) wr_count_q <= wr_count_q + 8'd1;
  end

  // Registered dump read port for the host.
  always_ff @(posedge clk) begin
    if (reset) dump_data_q <= '0;
    else       dump_data_q <= c_rdata;
  end

  mm_regfile #(.W(N), .DEPTH(DEPTH), .AW(AW)) u_a (
    .clk(clk), .clr_i(reset), .we_i(a_we), .waddr_i(rc_addr(ld_row, ld_col)),
    .wdata_i(ld_data), .raddr_i(eng_addr), .rdata_o(a_rdata)
  );

  mm_regfile #(.W(N), .DEPTH(DEPTH), .AW(AW)) u_b (
    .clk(clk), .clr_i(reset), .we_i(b_we), .waddr_i(rc_addr(ld_row, ld_col)),
    .wdata_i(ld_data), .raddr_i(eng_addr), .rdata_o(b_rdata)
  );

  mm_regfile #(.W(2*N), .DEPTH(DEPTH), .AW(AW)) u_c (
    .clk(clk), .clr_i(clr_c), .we_i(c_we), .waddr_i(eng_addr),
    .wdata_i(write_data), .raddr_i(rc_addr(dump_row, dump_col)), .rdata_o(c_rdata)
  );

endmodule

// File: tb/tb_mm_matrix_store.sv
// Scoreboard bench for mm_matrix_store: stimulus pushes expectations, a negedge monitor checks them.
module tb_mm_matrix_store;

  localparam int N    = 20;
  localparam int MAXD = 4;
  localparam int RW   = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            eng_reset;
  logic [N-1:0]    i, j;
  logic            read, write, index, finish;
  logic [N-1:0]    read_data;
  logic [2*N-1:0]  write_data;
  logic            ld_valid, ld_ready;
  logic [1:0]      ld_sel;
  logic [RW-1:0]   ld_row, ld_col;
  logic [N-1:0]    ld_data;
  logic            start;
  logic [RW-1:0]   dump_row, dump_col;
  logic [2*N-1:0]  dump_data;
  logic            busy, done, err;
  logic [7:0]      wr_count;

  mm_matrix_store #(.N(N), .MAXD(MAXD)) dut (
    .clk(clk), .reset(reset), .eng_reset(eng_reset),
    .i(i), .j(j), .read(read), .write(write), .index(index), .finish(finish),
    .read_data(read_data), .write_data(write_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data), .start(start),
    .dump_row(dump_row), .dump_col(dump_col), .dump_data(dump_data),
    .busy(busy), .done(done), .wr_count(wr_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef enum {S_RD, S_DUMP, S_WRC, S_ERR, S_DONE, S_BUSY, S_ENGRST, S_LDRDY} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [63:0] exp;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     passed = 0;
  longint exp_a[MAXD][MAXD];
  longint exp_b[MAXD][MAXD];

  function automatic logic [63:0] observe(sig_e s);
    case (s)
      S_RD:     return 64'(read_data);
      S_DUMP:   return 64'(dump_data);
      S_WRC:    return 64'(wr_count);
      S_ERR:    return 64'(err);
      S_DONE:   return 64'(done);
      S_BUSY:   return 64'(busy);
      S_ENGRST: return 64'(eng_reset);
      default:  return 64'(ld_ready);
    endcase
  endfunction

  task automatic expect_val(string name, sig_e s, logic [63:0] v);
    exp_t e;
    e.name = name;
    e.sig  = s;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // Monitor: compare every pending expectation against the DUT away from the active edge.
  initial begin
    exp_t        e;
    logic [63:0] got;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        got = observe(e.sig);
        checks++;
        if (got === e.exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", e.name, got, e.exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(logic [1:0] sel, int r, int c, longint d);
    ld_valid = 1'b1; ld_sel = sel; ld_row = RW'(r); ld_col = RW'(c); ld_data = d[N-1:0];
    step();
    ld_valid = 1'b0;
  endtask

  task automatic load_all(int ma, int mb, int mc);
    ld(2'd0, 0, 0, longint'(ma));
    ld(2'd0, 1, 0, longint'(mb));
    ld(2'd0, 2, 0, longint'(mc));
    for (int r = 0; r < ma; r++) for (int c = 0; c < mb; c++) ld(2'd1, r, c, exp_a[r][c]);
    for (int r = 0; r < mb; r++) for (int c = 0; c < mc; c++) ld(2'd2, r, c, exp_b[r][c]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic eng_size(int ii, longint expv, string nm);
    logic [63:0] e64;
    e64 = '0;
    e64[N-1:0] = expv[N-1:0];
    read = 1'b1; write = 1'b1; i = N'(ii); j = '0;
    expect_val(nm, S_RD, e64);
    step();
    read = 1'b0; write = 1'b0;
  endtask

  task automatic eng_read(logic idx, int r, int c, longint expv, string nm, output longint val);
    logic [63:0] e64;
    e64 = '0;
    e64[N-1:0] = expv[N-1:0];
    read = 1'b1; write = 1'b0; index = idx; i = N'(r); j = N'(c);
    expect_val(nm, S_RD, e64);
    @(negedge clk);
    val = longint'($signed(read_data));
    step();
    read = 1'b0;
  endtask

  task automatic eng_write(int r, int c, longint v);
    write = 1'b1; read = 1'b0; i = N'(r); j = N'(c); write_data = v[2*N-1:0];
    step();
    write = 1'b0;
  endtask

  // Behavioural engine: query sizes, read operands over the bus, write products back.
  task automatic run_engine(int ma, int mb, int mc);
    longint va, vb, acc;
    eng_size(0, longint'(ma), "size_ma");
    eng_size(1, longint'(mb), "size_mb");
    eng_size(2, longint'(mc), "size_mc");
    for (int r = 0; r < ma; r++) begin
      for (int c = 0; c < mc; c++) begin
        acc = 0;
        for (int k = 0; k < mb; k++) begin
          eng_read(1'b0, r, k, exp_a[r][k], "rd_a", va);
          eng_read(1'b1, k, c, exp_b[k][c], "rd_b", vb);
          acc += va * vb;
        end
        eng_write(r, c, acc);
      end
    end
    finish = 1'b1;
    step();
    finish = 1'b0;
  endtask

  task automatic dump_chk(int r, int c, logic [63:0] expv, string nm);
    dump_row = RW'(r); dump_col = RW'(c);
    step();
    expect_val(nm, S_DUMP, expv);
    step();
  endtask

  task automatic check_c_full(string nm);
    dump_chk(0, 0, 64'd58,  nm);
    dump_chk(0, 1, 64'd64,  nm);
    dump_chk(1, 0, 64'd139, nm);
    dump_chk(1, 1, 64'd154, nm);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; read = 0; write = 0; index = 0; finish = 0; i = '0; j = '0;
    write_data = '0; ld_valid = 0; ld_sel = '0; ld_row = '0; ld_col = '0; ld_data = '0;
    start = 0; dump_row = '0; dump_col = '0;
    exp_a = '{default: 0};
    exp_b = '{default: 0};
    exp_a[0][0] = 1; exp_a[0][1] = 2; exp_a[0][2] = 3;
    exp_a[1][0] = 4; exp_a[1][1] = 5; exp_a[1][2] = 6;
    exp_b[0][0] = 7;  exp_b[0][1] = 8;
    exp_b[1][0] = 9;  exp_b[1][1] = 10;
    exp_b[2][0] = 11; exp_b[2][1] = 12;

    // Reset state.
    step();
    expect_val("rst_eng_reset", S_ENGRST, 64'd1);
    expect_val("rst_ld_ready",  S_LDRDY,  64'd1);
    expect_val("rst_busy",      S_BUSY,   64'd0);
    expect_val("rst_done",      S_DONE,   64'd0);
    expect_val("rst_wr_count",  S_WRC,    64'd0);
    expect_val("rst_err",       S_ERR,    64'd0);
    expect_val("rst_dump",      S_DUMP,   64'd0);
    apply_reset();

    // Scenario 1: 2x3 * 3x2 product.
    load_all(2, 3, 2);
    pulse_start();
    expect_val("run_busy",      S_BUSY,   64'd1);
    expect_val("run_eng_reset", S_ENGRST, 64'd0);
    expect_val("run_ld_ready",  S_LDRDY,  64'd0);
    expect_val("run_wr_count0", S_WRC,    64'd0);
    run_engine(2, 3, 2);
    expect_val("s1_done",       S_DONE,   64'd1);
    expect_val("s1_eng_reset",  S_ENGRST, 64'd1);
    expect_val("s1_wr_count",   S_WRC,    64'd4);
    expect_val("s1_err",        S_ERR,    64'd0);
    check_c_full("s1_c");
    // Bus is dead in DONE.
    read = 1'b1; index = 1'b0; i = '0; j = N'(1);
    expect_val("done_rd_zero", S_RD, 64'd0);
    step();
    read = 1'b0;
    ld(2'd1, 0, 0, 99);

    // Scenario 6 (with the size-query boundary): rerun from DONE.
    pulse_start();
    expect_val("rerun_busy",  S_BUSY, 64'd1);
    expect_val("rerun_wrc0",  S_WRC,  64'd0);
    expect_val("rerun_err0",  S_ERR,  64'd0);
    dump_chk(1, 1, 64'd0, "rerun_c_cleared");
    ld(2'd2, 0, 0, 99);
    eng_size(3, 0, "size_bad_i");
    expect_val("size_bad_err", S_ERR, 64'd1);
    run_engine(2, 3, 2);
    expect_val("s6_done",     S_DONE, 64'd1);
    expect_val("s6_wr_count", S_WRC,  64'd4);
    check_c_full("s6_c");

    // Scenario 4/5: out-of-range write, then reset mid-RUN.
    pulse_start();
    expect_val("s4_err_cleared", S_ERR, 64'd0);
    eng_write(0, 0, 5);
    eng_write(4, 0, 777);
    expect_val("s4_wrc_oor", S_WRC, 64'd1);
    expect_val("s4_err_oor", S_ERR, 64'd1);
    eng_write(0, 1, 6);
    expect_val("s4_wrc_two", S_WRC, 64'd2);
    dump_chk(0, 0, 64'd5, "s4_c00_kept");
    apply_reset();
    expect_val("s5_busy",      S_BUSY,   64'd0);
    expect_val("s5_eng_reset", S_ENGRST, 64'd1);
    expect_val("s5_ld_ready",  S_LDRDY,  64'd1);
    expect_val("s5_wr_count",  S_WRC,    64'd0);
    expect_val("s5_err",       S_ERR,    64'd0);
    dump_chk(0, 0, 64'd0, "s5_c00_zero");
    dump_chk(0, 1, 64'd0, "s5_c01_zero");

    // Negative operands: 1x1 * 1x1.
    exp_a[0][0] = -3;
    exp_b[0][0] = 7;
    load_all(1, 1, 1);
    pulse_start();
    run_engine(1, 1, 1);
    expect_val("neg_done", S_DONE, 64'd1);
    dump_chk(0, 0, 64'h0000_00FF_FFFF_FFEB, "neg_c00");

    // Scenario 3: invalid sizes keep the block in LOAD.
    apply_reset();
    ld(2'd0, 0, 0, 2);
    ld(2'd0, 1, 0, 0);
    ld(2'd0, 2, 0, 2);
    pulse_start();
    expect_val("s3_zero_busy",      S_BUSY,   64'd0);
    expect_val("s3_zero_ld_ready",  S_LDRDY,  64'd1);
    expect_val("s3_zero_eng_reset", S_ENGRST, 64'd1);
    expect_val("s3_zero_err",       S_ERR,    64'd1);
    apply_reset();
    ld(2'd0, 0, 0, 2);
    ld(2'd0, 1, 0, 5);
    ld(2'd0, 2, 0, 2);
    expect_val("s3_pre_err", S_ERR, 64'd0);
    pulse_start();
    expect_val("s3_big_busy", S_BUSY, 64'd0);
    expect_val("s3_big_err",  S_ERR,  64'd1);

    step();
    step();
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
